// File: rtl/bilinear_neighbor_fetch.sv
// Parity-banked source-tile store with a 3-stage 2x2 neighbour fetch for the bilinear interpolator.
// At the right and bottom edges the last pixel is replicated and the matching offset is zeroed.
module bilinear_neighbor_fetch #(
    parameter int D_width = 6,
    parameter int X_int   = 6,
    parameter int Y_int   = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [X_int-1:0]         wr_x,
    input  logic [Y_int-1:0]         wr_y,
    input  logic [7:0]               wr_data,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [X_int+D_width-1:0] cx,
    input  logic [Y_int+D_width-1:0] cy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [D_width-1:0]       dx,
    output logic [D_width-1:0]       dy,
    output logic [7:0]               lu,
    output logic [7:0]               ru,
    output logic [7:0]               ld,
    output logic [7:0]               rd
);
    localparam int XA    = X_int - 1;
    localparam int YA    = Y_int - 1;
    localparam int AW    = XA + YA;
    localparam int DEPTH = 1 << AW;

    logic                  out_valid_q;
    logic                  advance;
    assign advance   = ~out_valid_q | out_ready;
    assign req_ready = advance;

    // ---------------- S1: decode ----------------
    logic [X_int-1:0]   x0;
    logic [Y_int-1:0]   y0;
    logic [X_int:0]     x0_p1;
    logic [Y_int:0]     y0_p1;
    logic [XA-1:0]      xa_even, xa_odd;
    logic [YA-1:0]      ya_even, ya_odd;
    logic               edge_x, edge_y;
    logic [3:0][AW-1:0] addr_d;

    assign x0      = cx[X_int+D_width-1:D_width];
    assign y0      = cy[Y_int+D_width-1:D_width];
    assign x0_p1   = {1'b0, x0} + (X_int+1)'(1);
    assign y0_p1   = {1'b0, y0} + (Y_int+1)'(1);
    // The even bank holds the (x0+1) column when x0 is odd; the wrap at the edge is never used.
    assign xa_even = x0_p1[X_int-1:1];
    assign xa_odd  = x0[X_int-1:1];
    assign ya_even = y0_p1[Y_int-1:1];
    assign ya_odd  = y0[Y_int-1:1];
    assign edge_x  = &x0;
    assign edge_y  = &y0;

    always_comb begin
        addr_d = '0;
        for (int b = 0; b < 4; b++) begin
            addr_d[b] = {(b[1] ? ya_odd : ya_even), (b[0] ? xa_odd : xa_even)};
        end
    end

    logic               v1_q, sx1_q, sy1_q, ex1_q, ey1_q;
    logic [D_width-1:0] dx1_q, dy1_q;
    logic [3:0][AW-1:0] addr1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sx1_q   <= 1'b0;
            sy1_q   <= 1'b0;
            ex1_q   <= 1'b0;
            ey1_q   <= 1'b0;
            dx1_q   <= '0;
            dy1_q   <= '0;
            addr1_q <= '0;
        end else if (advance) begin
            v1_q    <= req_valid;
            sx1_q   <= x0[0];
            sy1_q   <= y0[0];
            ex1_q   <= edge_x;
            ey1_q   <= edge_y;
            dx1_q   <= edge_x ? '0 : cx[D_width-1:0];
            dy1_q   <= edge_y ? '0 : cy[D_width-1:0];
            addr1_q <= addr_d;
        end
    end

    // ---------------- S2: banked RAM read ----------------
    logic [1:0]         wr_bank;
    logic [AW-1:0]      wr_addr;
    logic [3:0][7:0]    bank_rdata;

    assign wr_bank = {wr_y[0], wr_x[0]};
    assign wr_addr = {wr_y[Y_int-1:1], wr_x[X_int-1:1]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        logic [7:0] mem [DEPTH];
        logic [7:0] rdata_q;

        // Write and read share one process so a same-address collision returns the old pixel.
        always_ff @(posedge clk) begin
            if (wr_en && (wr_bank == 2'(gi))) begin
                mem[wr_addr] <= wr_data;
            end
            if (advance) begin
                rdata_q <= mem[addr1_q[gi]];
            end
        end

        assign bank_rdata[gi] = rdata_q;
    end

    logic               v2_q, sx2_q, sy2_q, ex2_q, ey2_q;
    logic [D_width-1:0] dx2_q, dy2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q  <= 1'b0;
            sx2_q <= 1'b0;
            sy2_q <= 1'b0;
            ex2_q <= 1'b0;
            ey2_q <= 1'b0;
            dx2_q <= '0;
            dy2_q <= '0;
        end else if (advance) begin
            v2_q  <= v1_q;
            sx2_q <= sx1_q;
            sy2_q <= sy1_q;
            ex2_q <= ex1_q;
            ey2_q <= ey1_q;
            dx2_q <= dx1_q;
            dy2_q <= dy1_q;
        end
    end

    // ---------------- S3: crossbar and edge substitution ----------------
    logic [7:0] lu_d, ru_d, ld_d, rd_d;

    always_comb begin
        lu_d = bank_rdata[{sy2_q, sx2_q}];
        ru_d = bank_rdata[{sy2_q, ~sx2_q}];
        ld_d = bank_rdata[{~sy2_q, sx2_q}];
        rd_d = bank_rdata[{~sy2_q, ~sx2_q}];
        if (ex2_q) begin
            ru_d = lu_d;
            rd_d = ld_d;
        end
        // Applied after the column rule so the corner collapses to a single pixel.
        if (ey2_q) begin
            ld_d = lu_d;
            rd_d = ru_d;
        end
    end

    logic [D_width-1:0] dx_q, dy_q;
    logic [7:0]         lu_q, ru_q, ld_q, rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            lu_q        <= '0;
            ru_q        <= '0;
            ld_q        <= '0;
            rd_q        <= '0;
        end else if (advance) begin
            out_valid_q <= v2_q;
            dx_q        <= dx2_q;
            dy_q        <= dy2_q;
            lu_q        <= lu_d;
            ru_q        <= ru_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign lu        = lu_q;
    assign ru        = ru_q;
    assign ld        = ld_q;
    assign rd        = rd_q;

endmodule
